// File: rtl/lsu_ctrl.sv
// Load/store unit: single outstanding memory op over valid/ready, with alignment
// checking, store lane steering and load extraction/extension.
module lsu_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_dop,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state, state_nx;
    logic [2:0]        dop_q;
    logic [1:0]        off_q;
    logic              we_q;
    logic              req_err;
    logic [3:0]        st_be;
    logic [31:0]       st_wdata;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_data;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_be_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;

    // Illegal dop is checked first; alignment only matters for legal h/w accesses.
    always_comb begin
        req_err = 1'b0;
        if (req_we) begin
            req_err = (req_dop > 3'd2);
        end else begin
            req_err = (req_dop == 3'd3) || (req_dop == 3'd6) || (req_dop == 3'd7);
        end
        if (req_dop[1:0] == 2'd1 && req_addr[0]) begin
            req_err = 1'b1;
        end
        if (req_dop[1:0] == 2'd2 && req_addr[1:0] != 2'd0) begin
            req_err = 1'b1;
        end
    end

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = req_wdata;
        if (req_we) begin
            case (req_dop[1:0])
                2'd0: begin
                    st_be    = 4'b0001 << req_addr[1:0];
                    st_wdata = {4{req_wdata[7:0]}};
                end
                2'd1: begin
                    st_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{req_wdata[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = req_wdata;
                end
            endcase
        end
    end

    always_comb begin
        ld_byte = 8'h00;
        case (off_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (dop_q)
            3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_data = {24'h0, ld_byte};
            3'd5:    ld_data = {16'h0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (req_valid) state_nx = req_err ? RESP : ISSUE;
            ISSUE: if (mem_gnt) state_nx = we_q ? RESP : WAIT;
            WAIT:  if (mem_rvalid) state_nx = RESP;
            default: state_nx = IDLE;
        endcase
    end

    // Response registers only change on entry to RESP so they hold between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            dop_q        <= 3'd0;
            off_q        <= 2'd0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= 4'd0;
            mem_wdata_q  <= 32'd0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q  <= req_we;
                        dop_q <= req_dop;
                        off_q <= req_addr[1:0];
                        if (req_err) begin
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'd0;
                        end else begin
                            mem_we_q    <= req_we;
                            mem_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_be_q    <= st_be;
                            mem_wdata_q <= st_wdata;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_gnt && we_q) begin
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= 32'd0;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= ld_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign mem_req    = (state == ISSUE);
    assign resp_valid = (state == RESP);
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: acts as the memory, scoreboards expected responses.
module tb_lsu_ctrl;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_dop;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_dop(req_dop), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkIssue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wdata);
        checkOutput("mem_req", {31'd0, mem_req}, 32'd1);
        checkOutput("mem_we", {31'd0, mem_we}, {31'd0, we});
        checkOutput("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        checkOutput("mem_be", {28'd0, mem_be}, {28'd0, be});
        if (we) checkOutput("mem_wdata", mem_wdata, wdata);
        checkOutput("busy_ready", {31'd0, req_ready}, 32'd0);
        checkOutput("early_resp", {31'd0, resp_valid}, 32'd0);
    endtask

    // One complete operation: request, memory behaviour, response and scoreboard check.
    task automatic applyStimulus(input logic we, input logic [2:0] dop, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input logic exp_err, input logic [31:0] exp_rdata,
                                 input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                                 input int gnt_dly, input int rv_dly);
        exp_t e;
        exp_t got;
        int   lat;
        checkOutput("req_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_dop   = dop;
        req_addr  = addr;
        req_wdata = wdata;
        e.rdata   = exp_rdata;
        e.err     = exp_err;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        if (exp_err) begin
            checkOutput("err_no_mem_req", {31'd0, mem_req}, 32'd0);
        end else begin
            for (int i = 0; i < gnt_dly; i++) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hBAD0_BAD0;
                checkIssue(we, addr, exp_be, exp_wdata);
                @(negedge clk);
            end
            mem_rvalid = 1'b0;
            checkIssue(we, addr, exp_be, exp_wdata);
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
            if (!we) begin
                for (int i = 0; i < rv_dly; i++) begin
                    checkOutput("wait_no_req", {31'd0, mem_req}, 32'd0);
                    checkOutput("wait_ready", {31'd0, req_ready}, 32'd0);
                    checkOutput("wait_resp", {31'd0, resp_valid}, 32'd0);
                    @(negedge clk);
                end
                mem_rvalid = 1'b1;
                mem_rdata  = rdata;
                @(negedge clk);
                mem_rvalid = 1'b0;
                mem_rdata  = 32'h0;
            end
        end
        lat = 0;
        while (!resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("resp_latency", lat, 0);
        if (sb.size() == 0) begin
            checkOutput("sb_nonempty", 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            checkOutput("resp_err", {31'd0, resp_err}, {31'd0, got.err});
            checkOutput("resp_rdata", resp_rdata, got.rdata);
        end
        @(negedge clk);
        checkOutput("resp_pulse_end", {31'd0, resp_valid}, 32'd0);
        checkOutput("ready_after", {31'd0, req_ready}, 32'd1);
        checkOutput("resp_rdata_hold", resp_rdata, exp_rdata);
    endtask

    task automatic checkResetValues();
        checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
        checkOutput("rst_resp_err", {31'd0, resp_err}, 32'd0);
        checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_be", {28'd0, mem_be}, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_dop = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkResetValues();

        // stores
        applyStimulus(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 32'h0, 4'b1111, 32'hDEADBEEF, 0, 0);
        applyStimulus(1'b1, 3'd0, 32'h103, 32'h000000A5, 32'h0, 1'b0, 32'h0, 4'b1000, 32'hA5A5A5A5, 0, 0);
        applyStimulus(1'b1, 3'd1, 32'h102, 32'h00001234, 32'h0, 1'b0, 32'h0, 4'b1100, 32'h12341234, 0, 0);
        applyStimulus(1'b1, 3'd0, 32'h101, 32'h0000003C, 32'h0, 1'b0, 32'h0, 4'b0010, 32'h3C3C3C3C, 1, 0);

        // loads
        applyStimulus(1'b0, 3'd0, 32'h201, 32'h0, 32'h00008000, 1'b0, 32'hFFFFFF80, 4'b1111, 32'h0, 0, 0);
        applyStimulus(1'b0, 3'd4, 32'h201, 32'h0, 32'h00008000, 1'b0, 32'h00000080, 4'b1111, 32'h0, 0, 0);
        applyStimulus(1'b0, 3'd1, 32'h202, 32'h0, 32'h80010000, 1'b0, 32'hFFFF8001, 4'b1111, 32'h0, 0, 0);
        applyStimulus(1'b0, 3'd5, 32'h202, 32'h0, 32'h80010000, 1'b0, 32'h00008001, 4'b1111, 32'h0, 0, 0);
        applyStimulus(1'b0, 3'd2, 32'h204, 32'h0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 4'b1111, 32'h0, 0, 0);

        // errors
        applyStimulus(1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 1'b1, 32'h0, 4'b1111, 32'h0, 0, 0);
        applyStimulus(1'b1, 3'd1, 32'h101, 32'h1234, 32'h0, 1'b1, 32'h0, 4'b0011, 32'h0, 0, 0);
        applyStimulus(1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 1'b1, 32'h0, 4'b1111, 32'h0, 0, 0);
        applyStimulus(1'b1, 3'd4, 32'h100, 32'h0, 32'h0, 1'b1, 32'h0, 4'b1111, 32'h0, 0, 0);

        // stalled memory, ISSUE also sees stray rvalid
        applyStimulus(1'b0, 3'd1, 32'h402, 32'h0, 32'h7FFF0000, 1'b0, 32'h00007FFF, 4'b1111, 32'h0, 3, 2);

        // reset while waiting for load data
        req_valid = 1'b1; req_we = 1'b0; req_dop = 3'd2; req_addr = 32'h300;
        @(negedge clk);
        req_valid = 1'b0;
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        checkOutput("in_wait", {31'd0, mem_req}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkResetValues();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        @(negedge clk);
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("stale_rvalid", {31'd0, resp_valid}, 32'd0);
            @(negedge clk);
        end
        checkResetValues();
        applyStimulus(1'b0, 3'd0, 32'h303, 32'h0, 32'h7F000000, 1'b0, 32'h0000007F, 4'b1111, 32'h0, 0, 1);

        checkOutput("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit sitting between the execute stage (ALU address, rs2 data, funct3) and the data-memory port. It accepts one memory operation at a time over a valid/ready handshake and checks alignment. For stores it drives byte-lane strobes and replicated write data. For loads it extracts and sign- or zero-extends the returned word, then presents a single-cycle response toward write-back.

## Interface
- ADDR_W, 32, byte address width
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  execute stage presents an operation
- req_ready  out  1  block can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_dop  in  3  funct3: 0 b, 1 h, 2 w, 4 bu, 5 hu
- req_addr  in  ADDR_W  byte address from ALU
- req_wdata  in  32  store data from rs2
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal dop; qualified by resp_valid
- mem_req  out  1  memory request, held until granted
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  word address, bits [1:0] forced to 0
- mem_be  out  4  byte enables, bit i = byte lane i (little-endian)
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  load word

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, capture we, dop, addr[1:0] and the lane data.
  - Error check: h/hu with addr[0]=1, w with addr[1:0]≠0, load dop ∈ {3,6,7}, store dop > 2. Error goes to RESP with resp_err=1 and no memory traffic.
  - No error: go to ISSUE.
- ISSUE: mem_req=1, and mem_we/addr/be/wdata are stable until the grant.
  - On mem_gnt, a store goes to RESP and a load goes to WAIT.
  - mem_rvalid seen in ISSUE is ignored.
- WAIT: on mem_rvalid, extract data, register it into resp_rdata, go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. The execute stage must take the response (no backpressure).
- Store lanes:
  - b: be = 1<<addr[1:0], wdata = {4{d[7:0]}}
  - h: be = addr[1] ? 1100 : 0011, wdata = {2{d[15:0]}}
  - w: be = 1111, wdata = d
  - Loads: be = 1111, mem_we = 0.
- Load extraction:
  - byte = rdata[8·addr[1:0] +: 8]
  - half = rdata[16·addr[1] +: 16]
  - lb/lh sign-extend, lbu/lhu zero-extend, lw passes through.
- Outputs are driven from registers and state only. There is no combinational path from mem_* inputs to resp_* outputs.

## Timing
- Reset: state = IDLE.
  - resp_valid=0, resp_rdata=0, resp_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
  - req_ready=1 from the first cycle after reset.
- Accept in cycle T (req_valid & req_ready at edge T):
  - Error: resp_valid in T+1.
  - Store with immediate grant: mem_req in T+1, resp_valid in T+2.
  - Load with gnt at T+1 and rvalid at T+2: resp_valid in T+3.
- Each extra cycle without mem_gnt or mem_rvalid adds one cycle of latency. There is no timeout.
- req_ready=0 from the cycle after acceptance through RESP. req_ready returns to 1 in the cycle after the resp_valid pulse, so at most one operation is in flight.
- rst asserted in any state forces IDLE and the reset output values at the next edge, including an outstanding mem_req.
  - The pending response is discarded.
  - A stale mem_rvalid arriving while in IDLE is ignored.
- resp_rdata and resp_err hold their value after the pulse until the next RESP.

## Test plan
- Reset, then store sw addr 0x100 data 0xDEADBEEF with gnt on first request cycle -> mem_addr 0x100, be 1111, wdata 0xDEADBEEF, resp_valid 2 cycles after accept, resp_err 0.
- sb addr 0x103 data 0x000000A5 -> be 1000, wdata 0xA5A5A5A5. sh addr 0x102 data 0x1234 -> be 1100, wdata 0x12341234.
- Load lb addr 0x201, mem_rdata 0x0000_8000 -> resp_rdata 0xFFFFFF80. lbu same -> 0x00000080. lh addr 0x202, rdata 0x80010000 -> 0xFFFF8001. lhu same -> 0x00008001.
- Misaligned lw addr 0x102, and sh addr 0x101 -> no mem_req, resp_valid next cycle, resp_err 1, resp_rdata 0. Also check load dop 3 -> resp_err 1.
- Stalled memory: gnt delayed 3 cycles, rvalid delayed 2 more -> mem_req/addr/be stable throughout, req_ready 0, single resp_valid pulse.
- rst asserted while in WAIT, then mem_rvalid pulse in IDLE -> no resp_valid, all outputs at reset values, next request accepted normally.
